fetch_unit: RTL and testbench

- Instruction fetch stage; sits directly upstream of the control/decode path.
- Fetches 16-bit instructions from instruction memory over a req/ack handshake and buffers them in a small prefetch FIFO.
- Presents one registered instruction per cycle as the ID-stage instruction register (o_ir_id).
- Obeys the ID stall and the branch/address-mode decision from the execute-stage control.

---
 rtl/fetch_unit.sv | 193 +++++++++++++++++++
 tb/tb_fetch_unit.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// ----------------------------------------------------------------------------
// fetch_unit
// Instruction fetch stage. Issues halfword-aligned requests to instruction
// memory over a req/ack handshake, buffers returned instructions in a small
// prefetch FIFO and presents one registered instruction per cycle to ID.
//
// Ports:
//   clk              rising-edge clock
//   rst              asynchronous active-low reset
//   i_stall_id       ID stalled: hold o_ir_id/o_pc_id/o_ir_valid, no pop
//   i_addr_mode      00 sequential, 01 branch/flush, 10/11 hold (no new req)
//   i_branch_target  branch destination, sampled when i_addr_mode==01
//   o_imem_req       instruction memory request
//   o_imem_addr      request address (halfword aligned)
//   i_imem_ack       transfer completes on an edge where req && ack
//   i_imem_data      instruction data, valid with ack
//   o_ir_id          registered instruction to ID
//   o_pc_id          address of o_ir_id
//   o_ir_valid       o_ir_id is a fetched instruction, not a bubble
// ----------------------------------------------------------------------------
module fetch_unit #(
    parameter int unsigned       ADDR_W    = 32,
    parameter int unsigned       DEPTH     = 2,
    parameter logic [ADDR_W-1:0] RESET_PC  = '0,
    parameter logic [15:0]       NOP_INSTR = 16'hBF00
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_stall_id,
    input  logic [1:0]        i_addr_mode,
    input  logic [ADDR_W-1:0] i_branch_target,
    output logic              o_imem_req,
    output logic [ADDR_W-1:0] o_imem_addr,
    input  logic              i_imem_ack,
    input  logic [15:0]       i_imem_data,
    output logic [15:0]       o_ir_id,
    output logic [ADDR_W-1:0] o_pc_id,
    output logic              o_ir_valid
);

    localparam int unsigned       PW      = $clog2(DEPTH);
    localparam int unsigned       CW      = PW + 1;
    localparam logic [CW-1:0]     DEPTH_C = CW'(DEPTH);
    localparam logic [ADDR_W-1:0] PC_RST  = RESET_PC & ~ADDR_W'(1);
    localparam logic [ADDR_W-1:0] PC_INC  = ADDR_W'(2);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DROP = 2'd2
    } state_t;

    state_t              r_state, w_state_nxt;
    logic                r_req, w_req_nxt;
    logic [ADDR_W-1:0]   r_addr, w_addr_nxt;
    logic [ADDR_W-1:0]   r_fetch_pc, w_fetch_pc_nxt;

    logic [15:0]         r_mem_ir [DEPTH];
    logic [ADDR_W-1:0]   r_mem_pc [DEPTH];
    logic [PW-1:0]       r_wptr, r_rptr;
    logic [CW-1:0]       r_count;

    logic [15:0]         r_ir;
    logic [ADDR_W-1:0]   r_pc;
    logic                r_valid;

    logic                w_flush, w_seq, w_push, w_pop;
    logic [CW-1:0]       w_cnt_after;
    logic [ADDR_W-1:0]   w_target;

    assign w_flush     = (i_addr_mode == 2'b01);
    assign w_seq       = (i_addr_mode == 2'b00);
    assign w_target    = i_branch_target & ~ADDR_W'(1);
    assign w_pop       = !w_flush && !i_stall_id && (r_count != '0);
    // Occupancy after a push this cycle, accounting for a concurrent pop so
    // that back-to-back issue sustains one instruction per cycle.
    assign w_cnt_after = r_count + CW'(1) - CW'(w_pop);

    always_comb begin
        w_state_nxt    = r_state;
        w_req_nxt      = r_req;
        w_addr_nxt     = r_addr;
        w_fetch_pc_nxt = r_fetch_pc;
        w_push         = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_seq && (r_count < DEPTH_C)) begin
                    w_state_nxt = S_WAIT;
                    w_req_nxt   = 1'b1;
                    w_addr_nxt  = r_fetch_pc;
                end
            end
            S_WAIT: begin
                if (w_flush) begin
                    // Data acked in the flush cycle is discarded outright;
                    // otherwise the request is left to complete in DROP.
                    if (i_imem_ack) begin
                        w_state_nxt = S_IDLE;
                        w_req_nxt   = 1'b0;
                    end else begin
                        w_state_nxt = S_DROP;
                    end
                end else if (i_imem_ack) begin
                    w_push         = 1'b1;
                    w_fetch_pc_nxt = r_fetch_pc + PC_INC;
                    if (w_seq && (w_cnt_after < DEPTH_C)) begin
                        w_addr_nxt = r_fetch_pc + PC_INC;
                    end else begin
                        w_state_nxt = S_IDLE;
                        w_req_nxt   = 1'b0;
                    end
                end
            end
            S_DROP: begin
                if (i_imem_ack) begin
                    w_state_nxt = S_IDLE;
                    w_req_nxt   = 1'b0;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_req_nxt   = 1'b0;
            end
        endcase
        if (w_flush) begin
            w_fetch_pc_nxt = w_target;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            r_req      <= 1'b0;
            r_addr     <= PC_RST;
            r_fetch_pc <= PC_RST;
        end else begin
            r_state    <= w_state_nxt;
            r_req      <= w_req_nxt;
            r_addr     <= w_addr_nxt;
            r_fetch_pc <= w_fetch_pc_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (w_flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + PW'(1);
            if (w_pop)  r_rptr <= r_rptr + PW'(1);
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_ir[r_wptr] <= i_imem_data;
            r_mem_pc[r_wptr] <= r_fetch_pc;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ir    <= NOP_INSTR;
            r_pc    <= '0;
            r_valid <= 1'b0;
        end else if (w_flush) begin
            r_ir    <= NOP_INSTR;
            r_valid <= 1'b0;
        end else if (!i_stall_id) begin
            if (w_pop) begin
                r_ir    <= r_mem_ir[r_rptr];
                r_pc    <= r_mem_pc[r_rptr];
                r_valid <= 1'b1;
            end else begin
                r_ir    <= NOP_INSTR;
                r_valid <= 1'b0;
            end
        end
    end

    assign o_imem_req  = r_req;
    assign o_imem_addr = r_addr;
    assign o_ir_id     = r_ir;
    assign o_pc_id     = r_pc;
    assign o_ir_valid  = r_valid;

endmodule

// File: tb/tb_fetch_unit.sv
// ----------------------------------------------------------------------------
// tb_fetch_unit
// Directed bench for fetch_unit (DEPTH=2, RESET_PC=0). Memory returns
// 16'h1000 + addr[15:0] for any address. A vector table covers sequential
// streaming, ID stall and hold mode; hand sequences cover flush with a late
// ack, ack coincident with flush, address wrap and reset mid-transfer.
// ----------------------------------------------------------------------------
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_stall_id;
    logic [1:0]  i_addr_mode;
    logic [31:0] i_branch_target;
    logic        o_imem_req;
    logic [31:0] o_imem_addr;
    logic        i_imem_ack;
    logic [15:0] i_imem_data;
    logic [15:0] o_ir_id;
    logic [31:0] o_pc_id;
    logic        o_ir_valid;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    fetch_unit #(
        .ADDR_W   (32),
        .DEPTH    (2),
        .RESET_PC (32'h0),
        .NOP_INSTR(16'hBF00)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .i_stall_id     (i_stall_id),
        .i_addr_mode    (i_addr_mode),
        .i_branch_target(i_branch_target),
        .o_imem_req     (o_imem_req),
        .o_imem_addr    (o_imem_addr),
        .i_imem_ack     (i_imem_ack),
        .i_imem_data    (i_imem_data),
        .o_ir_id        (o_ir_id),
        .o_pc_id        (o_pc_id),
        .o_ir_valid     (o_ir_valid)
    );

    function automatic logic [15:0] memf(input logic [31:0] a);
        return 16'h1000 + a[15:0];
    endfunction

    always_comb i_imem_data = memf(o_imem_addr);

    typedef struct {
        logic        stall;
        logic [1:0]  mode;
        logic        ack;
        logic        req;
        logic [31:0] addr;
        logic [15:0] ir;
        logic [31:0] pc;
        logic        valid;
    } vec_t;

    function automatic vec_t v(input logic s, input logic [1:0] m, input logic a,
                               input logic rq, input logic [31:0] ad,
                               input logic [15:0] ir, input logic [31:0] pc,
                               input logic vl);
        vec_t r;
        r.stall = s; r.mode = m; r.ack = a; r.req = rq;
        r.addr = ad; r.ir = ir; r.pc = pc; r.valid = vl;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic expect5(input string tag, input logic rq, input logic [31:0] ad,
                           input logic [15:0] ir, input logic [31:0] pc, input logic vl);
        chk({tag, " req"},   {31'b0, o_imem_req}, {31'b0, rq});
        chk({tag, " addr"},  o_imem_addr, ad);
        chk({tag, " ir"},    {16'b0, o_ir_id}, {16'b0, ir});
        chk({tag, " pc"},    o_pc_id, pc);
        chk({tag, " valid"}, {31'b0, o_ir_valid}, {31'b0, vl});
    endtask

    task automatic step(input logic s, input logic [1:0] m, input logic [31:0] t,
                        input logic a);
        i_stall_id      = s;
        i_addr_mode     = m;
        i_branch_target = t;
        i_imem_ack      = a;
        @(posedge clk);
        #1;
    endtask

    vec_t tbl[21];

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b0;
        i_stall_id = 1'b0;
        i_addr_mode = 2'b00;
        i_branch_target = '0;
        i_imem_ack = 1'b1;

        tbl[0]  = v(0, 2'd0, 1, 1, 32'h00, 16'hBF00, 32'h00, 0);
        tbl[1]  = v(0, 2'd0, 1, 1, 32'h02, 16'hBF00, 32'h00, 0);
        tbl[2]  = v(0, 2'd0, 1, 1, 32'h04, 16'h1000, 32'h00, 1);
        tbl[3]  = v(0, 2'd0, 1, 1, 32'h06, 16'h1002, 32'h02, 1);
        tbl[4]  = v(0, 2'd0, 1, 1, 32'h08, 16'h1004, 32'h04, 1);
        tbl[5]  = v(1, 2'd0, 1, 0, 32'h08, 16'h1004, 32'h04, 1);
        tbl[6]  = v(1, 2'd0, 1, 0, 32'h08, 16'h1004, 32'h04, 1);
        tbl[7]  = v(1, 2'd0, 1, 0, 32'h08, 16'h1004, 32'h04, 1);
        tbl[8]  = v(1, 2'd0, 1, 0, 32'h08, 16'h1004, 32'h04, 1);
        tbl[9]  = v(1, 2'd0, 1, 0, 32'h08, 16'h1004, 32'h04, 1);
        tbl[10] = v(0, 2'd0, 1, 0, 32'h08, 16'h1006, 32'h06, 1);
        tbl[11] = v(0, 2'd0, 1, 1, 32'h0A, 16'h1008, 32'h08, 1);
        tbl[12] = v(0, 2'd0, 1, 1, 32'h0C, 16'hBF00, 32'h08, 0);
        tbl[13] = v(0, 2'd0, 1, 1, 32'h0E, 16'h100A, 32'h0A, 1);
        tbl[14] = v(0, 2'd2, 1, 0, 32'h0E, 16'h100C, 32'h0C, 1);
        tbl[15] = v(0, 2'd2, 1, 0, 32'h0E, 16'h100E, 32'h0E, 1);
        tbl[16] = v(0, 2'd2, 1, 0, 32'h0E, 16'hBF00, 32'h0E, 0);
        tbl[17] = v(0, 2'd3, 1, 0, 32'h0E, 16'hBF00, 32'h0E, 0);
        tbl[18] = v(0, 2'd0, 1, 1, 32'h10, 16'hBF00, 32'h0E, 0);
        tbl[19] = v(0, 2'd0, 1, 1, 32'h12, 16'hBF00, 32'h0E, 0);
        tbl[20] = v(0, 2'd0, 1, 1, 32'h14, 16'h1010, 32'h10, 1);

        // Reset values, then release between edges.
        #12;
        expect5("reset", 1'b0, 32'h0, 16'hBF00, 32'h0, 1'b0);
        rst = 1'b1;

        for (int i = 0; i < 21; i++) begin
            step(tbl[i].stall, tbl[i].mode, 32'h0, tbl[i].ack);
            expect5($sformatf("row%0d", i), tbl[i].req, tbl[i].addr,
                    tbl[i].ir, tbl[i].pc, tbl[i].valid);
        end

        // Flush while a request is pending; ack arrives 3 cycles later.
        step(0, 2'b01, 32'h0000_0101, 0); expect5("fl1", 1, 32'h14, 16'hBF00, 32'h10, 0);
        step(0, 2'b00, 32'h0, 0);         expect5("fl2", 1, 32'h14, 16'hBF00, 32'h10, 0);
        step(0, 2'b00, 32'h0, 0);         expect5("fl3", 1, 32'h14, 16'hBF00, 32'h10, 0);
        step(0, 2'b00, 32'h0, 1);         expect5("fl4", 0, 32'h14, 16'hBF00, 32'h10, 0);
        step(0, 2'b00, 32'h0, 1);         expect5("fl5", 1, 32'h100, 16'hBF00, 32'h10, 0);
        step(0, 2'b00, 32'h0, 1);         expect5("fl6", 1, 32'h102, 16'hBF00, 32'h10, 0);
        step(0, 2'b00, 32'h0, 1);         expect5("fl7", 1, 32'h104, 16'h1100, 32'h100, 1);

        // Ack coincident with flush: that data must never reach o_ir_id.
        step(0, 2'b01, 32'h0000_0200, 1); expect5("fa1", 0, 32'h104, 16'hBF00, 32'h100, 0);
        step(0, 2'b00, 32'h0, 1);         expect5("fa2", 1, 32'h200, 16'hBF00, 32'h100, 0);
        step(0, 2'b00, 32'h0, 1);         expect5("fa3", 1, 32'h202, 16'hBF00, 32'h100, 0);
        step(0, 2'b00, 32'h0, 1);         expect5("fa4", 1, 32'h204, 16'h1200, 32'h200, 1);

        // Address wrap at the top of the address space (target bit0 ignored).
        step(0, 2'b01, 32'hFFFF_FFFF, 0); expect5("wr1", 1, 32'h204, 16'hBF00, 32'h200, 0);
        step(0, 2'b00, 32'h0, 1);         expect5("wr2", 0, 32'h204, 16'hBF00, 32'h200, 0);
        step(0, 2'b00, 32'h0, 1);         expect5("wr3", 1, 32'hFFFF_FFFE, 16'hBF00, 32'h200, 0);
        step(0, 2'b00, 32'h0, 1);         expect5("wr4", 1, 32'h0, 16'hBF00, 32'h200, 0);
        step(0, 2'b00, 32'h0, 1);         expect5("wr5", 1, 32'h2, 16'h0FFE, 32'hFFFF_FFFE, 1);
        step(0, 2'b00, 32'h0, 0);         expect5("wr6", 1, 32'h2, 16'h1000, 32'h0, 1);

        // Reset asserted mid-WAIT: outputs clear without waiting for an edge.
        #2;
        rst = 1'b0;
        #1;
        expect5("rstmid", 0, 32'h0, 16'hBF00, 32'h0, 0);
        i_imem_ack = 1'b1;
        #3;
        rst = 1'b1;
        step(0, 2'b00, 32'h0, 1);         expect5("rl1", 1, 32'h0, 16'hBF00, 32'h0, 0);
        step(0, 2'b00, 32'h0, 1);         expect5("rl2", 1, 32'h2, 16'hBF00, 32'h0, 0);
        step(0, 2'b00, 32'h0, 1);         expect5("rl3", 1, 32'h4, 16'h1000, 32'h0, 1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
